// File: rtl/pixel_packer.sv
// Packs PACK pixels from the filter FIFO into one word with SOF/EOL flags for the output FIFO.
// Define PIXEL_PACKER_BORDER_ZERO_EN to zero pixels that fall inside the BORDER-wide frame edge.
module pixel_packer #(
  parameter int DWIDTH_IN  = 8,
  parameter int PACK       = 4,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int BORDER     = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic                      fifo_in_rd_en,
  input  logic [DWIDTH_IN-1:0]      fifo_in_dout,
  input  logic                      fifo_in_empty,
  output logic                      fifo_out_wr_en,
  output logic [DWIDTH_IN*PACK+1:0] fifo_out_din,
  input  logic                      fifo_out_full,
  output logic                      frame_done,
  output logic [1:0]                state_dbg_o
);

  localparam int LW  = $clog2(PACK);
  localparam int WPL = IMG_WIDTH / PACK;
  localparam int XW  = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int YW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int AW  = DWIDTH_IN * (PACK - 1);
  localparam int OW  = DWIDTH_IN * PACK + 2;

  localparam logic [LW-1:0] LANE_LAST = LW'(PACK - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(WPL - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(IMG_HEIGHT - 1);

  if (PACK < 2 || (IMG_WIDTH % PACK) != 0 || BORDER < 0) begin : g_bad_params
    $error("pixel_packer: PACK must be >= 2 and divide IMG_WIDTH, BORDER >= 0");
  end

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [XW-1:0]   x_word_q, x_word_d;
  logic [YW-1:0]   y_q, y_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [OW-1:0]   hold_q, hold_d;
  logic            out_valid_q, out_valid_d;

  logic                 pop;
  logic                 load;
  logic                 last_lane;
  logic                 wrap_x;
  logic                 last_row;
  logic                 sof;
  logic [DWIDTH_IN-1:0] pix_w;

  // Handshakes: a pop happens on any edge where fifo_in_rd_en=1 (implies !fifo_in_empty);
  // a push happens on any edge where fifo_out_wr_en=1 (implies !fifo_out_full).
  always_comb begin
    fifo_in_rd_en  = (state_q == S_RUN) && !fifo_in_empty &&
                     ((lane_q != LANE_LAST) || !out_valid_q || !fifo_out_full);
    fifo_out_wr_en = out_valid_q && !fifo_out_full;
    frame_done     = (state_q == S_DRAIN) && fifo_out_wr_en;
    state_dbg_o    = state_q;
  end

  assign fifo_out_din = hold_q;

  always_comb begin
    pix_w = fifo_in_dout;
`ifdef PIXEL_PACKER_BORDER_ZERO_EN
    begin
      int col;
      col = int'(x_word_q) * PACK + int'(lane_q);
      if (col < BORDER || col >= IMG_WIDTH - BORDER ||
          int'(y_q) < BORDER || int'(y_q) >= IMG_HEIGHT - BORDER) begin
        pix_w = '0;
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (load && wrap_x && last_row) state_d = S_DRAIN;
      S_DRAIN: if (fifo_out_wr_en) state_d = S_DONE;
      S_DONE:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    pop         = fifo_in_rd_en;
    last_lane   = (lane_q == LANE_LAST);
    load        = pop && last_lane;
    wrap_x      = (x_word_q == X_LAST);
    last_row    = (y_q == Y_LAST);
    sof         = (x_word_q == '0) && (y_q == '0);

    acc_d       = acc_q;
    lane_d      = lane_q;
    hold_d      = hold_q;
    x_word_d    = x_word_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;

    if (pop) begin
      if (last_lane) begin
        lane_d = '0;
      end else begin
        lane_d = lane_q + LW'(1);
        acc_d[lane_q*DWIDTH_IN +: DWIDTH_IN] = pix_w;
      end
    end

    // The last lane goes straight into the holding register alongside the stored lanes.
    if (load) begin
      hold_d      = {sof, wrap_x, pix_w, acc_q};
      out_valid_d = 1'b1;
      if (wrap_x) begin
        x_word_d = '0;
        y_d      = last_row ? '0 : y_q + YW'(1);
      end else begin
        x_word_d = x_word_q + XW'(1);
      end
    end else if (fifo_out_wr_en) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lane_q      <= '0;
      x_word_q    <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      lane_q      <= lane_d;
      x_word_q    <= x_word_d;
      y_q         <= y_d;
      acc_q       <= acc_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer on an 8x2 frame with PACK=4: framing, stalls, empty gaps, reset.
module tb_pixel_packer;

  localparam int DW   = 8;
  localparam int PACK = 4;
  localparam int W    = 8;
  localparam int H    = 2;
  localparam int OW   = DW * PACK + 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          fifo_in_rd_en;
  logic [DW-1:0] fifo_in_dout;
  logic          fifo_in_empty;
  logic          fifo_out_wr_en;
  logic [OW-1:0] fifo_out_din;
  logic          fifo_out_full = 1'b0;
  logic          frame_done;
  logic [1:0]    state_dbg;

  pixel_packer #(
    .DWIDTH_IN (DW),
    .PACK      (PACK),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .BORDER    (1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .fifo_in_rd_en (fifo_in_rd_en),
    .fifo_in_dout  (fifo_in_dout),
    .fifo_in_empty (fifo_in_empty),
    .fifo_out_wr_en(fifo_out_wr_en),
    .fifo_out_din  (fifo_out_din),
    .fifo_out_full (fifo_out_full),
    .frame_done    (frame_done),
    .state_dbg_o   (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- input FIFO model and output monitor ----------------
  logic [DW-1:0] mem [0:255];
  logic          empty_force = 1'b0;
  int            fill_end = 0;
  int            pop_total = 0;
  int            got_total = 0;
  int            fd_total = 0;
  int            done_cyc_total = 0;
  int            cyc = 0;
  int            pop_cyc [0:255];
  logic [OW-1:0] got_mem [0:63];
  logic          got_fd  [0:63];

  assign fifo_in_dout  = mem[pop_total[7:0]];
  assign fifo_in_empty = empty_force || (pop_total >= fill_end);

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (fifo_in_rd_en) begin
      pop_cyc[pop_total[7:0]] <= cyc;
      pop_total <= pop_total + 1;
    end
    if (fifo_out_wr_en) begin
      got_mem[got_total[5:0]] <= fifo_out_din;
      got_fd[got_total[5:0]]  <= frame_done;
      got_total <= got_total + 1;
    end
    if (frame_done) fd_total <= fd_total + 1;
    if (state_dbg == 2'd2) done_cyc_total <= done_cyc_total + 1;
  end

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic load_pixels(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) mem[(fill_end + i) % 256] = first + 8'(i);
    fill_end = fill_end + n;
  endtask

  task automatic push_frame(input logic [7:0] first, input logic zero_data);
    logic [OW-1:0] word;
    for (int w = 0; w < 4; w++) begin
      word = '0;
      if (!zero_data)
        for (int k = 0; k < 4; k++) word[k*8 +: 8] = first + 8'(w * 4 + k);
      word[OW-1] = (w == 0);
      word[OW-2] = (w % 2 == 1);
      exp_q.push_back(word);
    end
  endtask

  task automatic expect_words(input int base, input string tag);
    int idx;
    logic [OW-1:0] e;
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, got_mem[base + idx], e);
      idx++;
    end
  endtask

  task automatic wait_words(input int target, input int budget);
    int k;
    k = 0;
    while (got_total < target && k < budget) begin
      @(negedge clock);
      k++;
    end
    check("words_done", got_total, target);
  endtask

  // ---------------- directed sequence ----------------
  int base;
  int p0;
  int g0;
  int k;

  initial begin
    tick(2);
    check("rst_rd_en", fifo_in_rd_en, 0);
    check("rst_wr_en", fifo_out_wr_en, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_din", fifo_out_din, 0);
    check("rst_state", state_dbg, 0);

`ifdef PIXEL_PACKER_BORDER_ZERO_EN
    load_pixels(16, 8'hFF);
    for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
    reset = 1'b1;
    wait_words(4, 200);
    push_frame(8'h00, 1'b1);
    expect_words(0, "border_word");
    check("border_fd", got_fd[3], 1);
`else
    // Two back-to-back frames, continuous input, output never full.
    load_pixels(32, 8'h01);
    reset = 1'b1;
    wait_words(8, 300);
    tick(3);
    push_frame(8'h01, 1'b0);
    push_frame(8'h11, 1'b0);
    expect_words(0, "cont_word");
    check("cont_fd_w2", got_fd[2], 0);
    check("cont_fd_w3", got_fd[3], 1);
    check("cont_fd_w7", got_fd[7], 1);
    check("cont_fd_total", fd_total, 2);
    check("cont_done_cycles", done_cyc_total, 2);
    check("cont_no_bubble_f1", pop_cyc[15] - pop_cyc[0], 15);
    check("cont_no_bubble_f2", pop_cyc[31] - pop_cyc[16], 15);
    check("cont_frame_gap", pop_cyc[16] - pop_cyc[15], 3);

    // Output FIFO full from the first cycle.
    reset = 1'b0;
    fifo_out_full = 1'b1;
    tick(1);
    base = got_total;
    p0 = pop_total;
    load_pixels(16, 8'h41);
    reset = 1'b1;
    tick(20);
    check("full_pops", pop_total - p0, 2 * PACK - 1);
    check("full_rd_en_off", fifo_in_rd_en, 0);
    check("full_no_write", got_total - base, 0);
    fifo_out_full = 1'b0;
    #1;
    check("release_wr_en", fifo_out_wr_en, 1);
    check("release_rd_en", fifo_in_rd_en, 1);
    wait_words(base + 4, 200);
    tick(3);
    push_frame(8'h41, 1'b0);
    expect_words(base, "full_word");
    check("full_fd", got_fd[base + 3], 1);

    // Input FIFO empty on alternate cycles.
    base = got_total;
    load_pixels(16, 8'h61);
    k = 0;
    while (got_total < base + 4 && k < 300) begin
      @(negedge clock);
      empty_force = ~empty_force;
      k++;
    end
    empty_force = 1'b0;
    check("gap_words", got_total - base, 4);
    tick(3);
    push_frame(8'h61, 1'b0);
    expect_words(base, "gap_word");
    check("gap_fd", got_fd[base + 3], 1);

    // Reset after 6 pops with a word pending behind a full output FIFO.
    fifo_out_full = 1'b1;
    p0 = pop_total;
    load_pixels(6, 8'h81);
    k = 0;
    while (pop_total - p0 < 6 && k < 50) begin
      @(negedge clock);
      k++;
    end
    check("pre_reset_pops", pop_total - p0, 6);
    reset = 1'b0;
    #1;
    check("midrst_rd_en", fifo_in_rd_en, 0);
    check("midrst_wr_en", fifo_out_wr_en, 0);
    check("midrst_din", fifo_out_din, 0);
    check("midrst_frame_done", frame_done, 0);
    check("midrst_state", state_dbg, 0);
    g0 = got_total;
    @(negedge clock);
    check("midrst_no_write", got_total, g0);
    reset = 1'b1;
    fifo_out_full = 1'b0;
    load_pixels(16, 8'hC1);
    wait_words(g0 + 4, 200);
    tick(3);
    push_frame(8'hC1, 1'b0);
    expect_words(g0, "post_rst_word");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pixel_packer.md
PIXEL_PACKER -- requirements
Module: pixel_packer

Interface
REQ-001 Parameter DWIDTH_IN, default 8, is the pixel width popped from the input FIFO.
REQ-002 Parameter PACK, default 4, is pixels per output word; PACK SHALL be ≥2, and IMG_WIDTH SHALL be divisible by PACK.
REQ-003 Parameter IMG_WIDTH, default 720, is pixels per line.
REQ-004 Parameter IMG_HEIGHT, default 540, is lines per frame.
REQ-005 Parameter BORDER, default 1, is the border width in pixels.
REQ-006 clock  in  1  single clock for all logic.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 fifo_in_rd_en  out  1  pops one pixel from the filter output FIFO.
REQ-009 fifo_in_dout  in  DWIDTH_IN  pixel at the head of the input FIFO.
REQ-010 fifo_in_empty  in  1  input FIFO empty.
REQ-011 fifo_out_wr_en  out  1  pushes one packed word.
REQ-012 fifo_out_din  out  DWIDTH_IN*PACK+2  bit [MSB] is SOF, bit [MSB-1] is EOL, and the low bits are pixels, with lane 0 in the LSBs.
REQ-013 fifo_out_full  in  1  output FIFO full.
REQ-014 frame_done  out  1  one-cycle pulse when the last word of a frame is pushed.

Function
REQ-015 The block SHALL pop one pixel per cycle whenever state=RUN, fifo_in_empty=0, and the pixel will not overflow the accumulator, with no bubbles.
REQ-016 fifo_in_rd_en SHALL be combinational: RUN && !fifo_in_empty && (lane<PACK-1 || !out_valid || !fifo_out_full).
REQ-017 Each popped pixel SHALL be written into accumulator lane `lane`; lane then increments and wraps from PACK-1 to 0.
REQ-018 The pop that fills lane PACK-1 SHALL, on the same edge, load the holding register, set out_valid=1, and capture SOF=(x_word==0 && y==0) and EOL=(x_word==IMG_WIDTH/PACK-1).
REQ-019 fifo_out_wr_en SHALL be combinational out_valid && !fifo_out_full; fifo_out_din SHALL be driven from the holding register.
REQ-020 out_valid SHALL clear on a write unless a new word is loaded on the same edge, in which case it stays 1 (a simultaneous load and write is legal).
REQ-021 Latency from the pop of the last pixel of a word to fifo_out_wr_en SHALL be 1 cycle when the output FIFO is not full.
REQ-022 x_word SHALL count 0..IMG_WIDTH/PACK-1 per loaded word and wrap to 0; y SHALL increment on that wrap.
REQ-023 On loading the word with y=IMG_HEIGHT-1 and EOL=1, the FSM SHALL go RUN→DRAIN; x_word and y SHALL reset to 0.
REQ-024 DRAIN: no pops; the FSM SHALL stay in DRAIN until the pending word is written.
REQ-025 On the cycle the pending word is written in DRAIN, frame_done SHALL be 1 and the FSM SHALL go to DONE.
REQ-026 DONE SHALL last exactly one cycle, then go to RUN; the next frame starts with SOF.
REQ-027 A full output FIFO SHALL stall the input only when the accumulator needs the holding register; up to PACK-1 pixels SHALL still be absorbed while stalled.
REQ-028 An empty input FIFO SHALL hold all counters and leave the pending word writable.

Reset
REQ-029 With reset=0, asynchronously: state=RUN, lane=0, x_word=0, y=0, out_valid=0, holding register=0, accumulator=0, frame_done=0.
REQ-030 Consequently fifo_in_rd_en=0 and fifo_out_wr_en=0 during reset.
REQ-031 Reset mid-frame SHALL discard partial words and the pending word; no write SHALL occur during the reset cycle.

Configuration
REQ-032 With macro PIXEL_PACKER_BORDER_ZERO_EN defined, a pixel at column x<BORDER, x≥IMG_WIDTH-BORDER, row y<BORDER, or y≥IMG_HEIGHT-BORDER SHALL be written into its lane as 0.
REQ-033 Without PIXEL_PACKER_BORDER_ZERO_EN, pixels SHALL pass unmodified and no pixel column counter SHALL be synthesized beyond lane/x_word.

Verification
REQ-034 Bench config: IMG_WIDTH=8, IMG_HEIGHT=2, PACK=4, input never empty, output never full; push pixels 0x01..0x10. Required: 4 writes, first data 0x04030201 with SOF=1 EOL=0, second data 0x08070605 with SOF=0 EOL=1, frame_done pulses on the 4th write, and no rd_en bubbles.
REQ-035 Stimulus: hold fifo_out_full=1 from cycle 0. Required: exactly 2*PACK-1=7 pops then rd_en=0; after release, the word writes next cycle and pops resume in the same cycle.
REQ-036 Stimulus: toggle fifo_in_empty every cycle. Required: the output sequence is identical to the continuous case; only timing changes.
REQ-037 Stimulus: assert reset for one cycle after 6 pops. Required: all outputs 0 and the following first word carries SOF=1 with the new pixels.
REQ-038 Stimulus: with PIXEL_PACKER_BORDER_ZERO_EN and BORDER=1 on the 8x2 all-0xFF frame. Required: every word is 0x00000000.
REQ-039 Stimulus: two back-to-back frames. Required: exactly one DONE cycle between frames and SOF set on the first word of each frame.
